wall_scroller: RTL and testbench
================================

Name: wall_scroller

Overview:
Generates the scrolling wall (pipe) for the game and drives the wall coordinate inputs of the collision checker downstream.
- Holds one wall; moves it left by SPEED pixels on every frame tick.
- When the wall leaves the left edge, respawns it at the right edge with a pseudo-random gap height from an internal LFSR.
- Emits a one-cycle score pulse when the wall's right edge passes the bird column.
- Freezes on a halt request (collision) until the next start.

Parameters:
SPAWN_X, 159, xleft loaded at spawn (rightmost screen column)
WALL_W, 16, wall width in pixels; xright = xleft + WALL_W - 1
SPEED, 1, pixels moved per frame tick (must be < WALL_W)
GAP_MIN, 8, smallest wall_topy value
GAP_H, 40, vertical gap size; bottomy = topy + GAP_H
BIRD_X, 40, bird's right-edge column used for the passed pulse
LFSR_SEED, 8'hA5, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: spawn a fresh wall and begin scrolling
halt  in  1  level: freeze wall (driven from touched)
frame_tick  in  1  one-cycle pulse per video frame
wall_xleft  out  9  wall left column
wall_xright  out  9  wall right column
wall_topy  out  7  bottom row of upper pipe
wall_bottomy  out  7  top row of lower pipe
wall_valid  out  1  coordinates are meaningful (SCROLL or HALT)
passed  out  1  one-cycle pulse, wall cleared BIRD_X

Behaviour:
- Reset, applied asynchronously, puts the block in these values:
  - state IDLE
  - xleft = SPAWN_X, topy = GAP_MIN
  - wall_valid = 0, passed = 0
  - lfsr = LFSR_SEED
- Combinational outputs:
  - wall_xright = xleft + WALL_W - 1, computed at 9 bits; SPAWN_X + WALL_W - 1 = 174 fits.
  - wall_bottomy = topy + GAP_H.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every clock regardless of state and never reaches zero.
- Gap draw: topy <= GAP_MIN + lfsr[5:0]. Range is [8,71], so bottomy ≤ 111 < 120.
- States IDLE, SCROLL, RESPAWN, HALT. Registered state; all outputs registered except xright and bottomy.
- Priority each cycle is reset > start > halt > frame_tick.
- IDLE:
  - wall_valid = 0.
  - start -> RESPAWN. Other inputs ignored.
- RESPAWN (exactly 1 cycle):
  - load xleft = SPAWN_X and topy from the gap draw.
  - wall_valid = 0.
  - -> SCROLL unconditionally; halt and tick in this cycle are ignored.
- SCROLL:
  - wall_valid = 1.
  - start -> RESPAWN (restart).
  - else halt -> HALT, with no move even if frame_tick is high the same cycle.
  - else on frame_tick:
    - if xleft < SPEED -> RESPAWN; the wall has left the screen.
    - otherwise xleft <= xleft - SPEED.
    - passed = 1 for that cycle iff old xright ≥ BIRD_X and new xright < BIRD_X.
- HALT:
  - wall_valid = 1; coordinates frozen.
  - frame_tick ignored.
  - start -> RESPAWN. Dropping halt does not resume; only start does.
- passed is 0 in every cycle other than the move cycle above. It is never asserted in the RESPAWN cycle.
- Underflow: xleft never goes negative, because the wrap check precedes the subtract.
- Reset mid-scroll: immediate return to IDLE values; passed deasserts asynchronously.

Decomposition:
- Shared game package (game_pkg) holds:
  - screen constants SCREEN_W=160 and SCREEN_H=120
  - coordinate widths X_W=9 and Y_W=7
  - the state enum
  - default wall geometry constants, so the bird, collision and renderer blocks agree.
- One natural sub-module: lfsr8, a free-running 8-bit LFSR with a seed parameter, reusable by other random events.

Test Plan:
- Reset release, then start, then 1 clock: state RESPAWN, wall_valid=0. Next cycle: wall_valid=1, xleft=159, xright=174, topy=GAP_MIN+(lfsr[5:0] at draw), bottomy=topy+40.
- 159 frame_ticks with SPEED=1: xleft steps to 0. Tick 160 -> RESPAWN. One cycle later xleft=159 with a new topy, which differs from the previous draw for seed A5.
- Passed pulse: passed is high for exactly one cycle, on the tick that moves xright from 40 to 39 (xleft 25 -> 24). No other pulse occurs across a full traverse.
- halt and frame_tick high in the same cycle at xleft=100: xleft stays 100 and state goes to HALT. Further ticks, and dropping halt, leave xleft=100 and wall_valid=1. start -> respawn at 159.
- start pulsed mid-scroll at xleft=70: RESPAWN next cycle, then xleft=159. No passed pulse.
- Async reset asserted mid-scroll between clock edges: outputs return to IDLE values without waiting for clk. lfsr = A5 after release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, coordinate widths, wall FSM states and LFSR step
// function used by the bird, wall, collision and renderer blocks.
package game_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 9;
  localparam int Y_W      = 7;

  localparam int WALL_SPAWN_X = 159;
  localparam int WALL_WIDTH   = 16;
  localparam int WALL_SPEED   = 1;
  localparam int WALL_GAP_MIN = 8;
  localparam int WALL_GAP_H   = 40;
  localparam int BIRD_COL_X   = 40;
  localparam logic [7:0] WALL_LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    WS_IDLE    = 2'd0,
    WS_RESPAWN = 2'd1,
    WS_SCROLL  = 2'd2,
    WS_HALT    = 2'd3
  } wall_state_e;

  // Fibonacci step for x^8+x^6+x^5+x^4+1; a non-zero state never maps to zero.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
endpackage

// File: rtl/wall_scroller_lfsr8.sv
// Free-running 8-bit maximal-length LFSR; shifts every clock, held at SEED in reset.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = WALL_LFSR_SEED
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_lfsr
);
  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= SEED;
    else       r_lfsr <= lfsr8_step(r_lfsr);
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/wall_scroller.sv
// Single scrolling wall: moves left on frame ticks, respawns at the right edge
// with a random gap, pulses passed when it clears the bird column.
module wall_scroller
  import game_pkg::*;
#(
  parameter int         SPAWN_X   = WALL_SPAWN_X,
  parameter int         WALL_W    = WALL_WIDTH,
  parameter int         SPEED     = WALL_SPEED,
  parameter int         GAP_MIN   = WALL_GAP_MIN,
  parameter int         GAP_H     = WALL_GAP_H,
  parameter int         BIRD_X    = BIRD_COL_X,
  parameter logic [7:0] LFSR_SEED = WALL_LFSR_SEED
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           halt,
  input  logic           frame_tick,
  output logic [X_W-1:0] wall_xleft,
  output logic [X_W-1:0] wall_xright,
  output logic [Y_W-1:0] wall_topy,
  output logic [Y_W-1:0] wall_bottomy,
  output logic           wall_valid,
  output logic           passed
);
  localparam logic [X_W-1:0] C_SPAWN_X = X_W'(SPAWN_X);
  localparam logic [X_W-1:0] C_SPEED   = X_W'(SPEED);
  localparam logic [X_W-1:0] C_XR_OFS  = X_W'(WALL_W - 1);
  localparam logic [X_W-1:0] C_BIRD_X  = X_W'(BIRD_X);
  localparam logic [Y_W-1:0] C_GAP_MIN = Y_W'(GAP_MIN);
  localparam logic [Y_W-1:0] C_GAP_H   = Y_W'(GAP_H);

  wall_state_e    r_state, w_state_nxt;
  logic [X_W-1:0] r_xleft, w_xleft_nxt;
  logic [Y_W-1:0] r_topy, w_topy_nxt;
  logic           r_valid, r_passed, w_passed_nxt;

  logic [7:0]     w_lfsr;
  logic [Y_W-1:0] w_draw;
  logic [X_W-1:0] w_xleft_mv, w_xr_old, w_xr_new;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_draw     = C_GAP_MIN + {1'b0, w_lfsr[5:0]};
  assign w_xleft_mv = r_xleft - C_SPEED;
  assign w_xr_old   = r_xleft + C_XR_OFS;
  assign w_xr_new   = w_xleft_mv + C_XR_OFS;

  // Wrap test is evaluated before the subtract so xleft can never underflow.
  always_comb begin
    w_state_nxt  = r_state;
    w_xleft_nxt  = r_xleft;
    w_topy_nxt   = r_topy;
    w_passed_nxt = 1'b0;
    case (r_state)
      WS_IDLE: begin
        if (start) w_state_nxt = WS_RESPAWN;
      end
      WS_RESPAWN: begin
        w_xleft_nxt = C_SPAWN_X;
        w_topy_nxt  = w_draw;
        w_state_nxt = WS_SCROLL;
      end
      WS_SCROLL: begin
        if (start)                  w_state_nxt = WS_RESPAWN;
        else if (halt)              w_state_nxt = WS_HALT;
        else if (frame_tick) begin
          if (r_xleft < C_SPEED)    w_state_nxt = WS_RESPAWN;
          else begin
            w_xleft_nxt  = w_xleft_mv;
            w_passed_nxt = (w_xr_old >= C_BIRD_X) && (w_xr_new < C_BIRD_X);
          end
        end
      end
      WS_HALT: begin
        if (start) w_state_nxt = WS_RESPAWN;
      end
      default: w_state_nxt = WS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WS_IDLE;
      r_xleft  <= C_SPAWN_X;
      r_topy   <= C_GAP_MIN;
      r_valid  <= 1'b0;
      r_passed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_xleft  <= w_xleft_nxt;
      r_topy   <= w_topy_nxt;
      r_valid  <= (w_state_nxt == WS_SCROLL) || (w_state_nxt == WS_HALT);
      r_passed <= w_passed_nxt;
    end
  end

  assign wall_xleft   = r_xleft;
  assign wall_xright  = r_xleft + C_XR_OFS;
  assign wall_topy    = r_topy;
  assign wall_bottomy = r_topy + C_GAP_H;
  assign wall_valid   = r_valid;
  assign passed       = r_passed;
endmodule

// File: tb/tb_wall_scroller.sv
// Directed bench for wall_scroller: spawn, full traverse, passed pulse,
// halt freeze, mid-scroll restart and asynchronous reset.
module tb_wall_scroller;
  logic       clk = 1'b0;
  logic       reset, start, halt, frame_tick;
  logic [8:0] wall_xleft, wall_xright;
  logic [6:0] wall_topy, wall_bottomy;
  logic       wall_valid, passed;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt, pulse_xl;
  logic [7:0] m_lfsr;
  logic [6:0] top1, top2;

  wall_scroller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .frame_tick   (frame_tick),
    .wall_xleft   (wall_xleft),
    .wall_xright  (wall_xright),
    .wall_topy    (wall_topy),
    .wall_bottomy (wall_bottomy),
    .wall_valid   (wall_valid),
    .passed       (passed)
  );

  always #5 clk = ~clk;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, seed A5.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (passed) begin
      pulse_cnt++;
      pulse_xl = int'(wall_xleft);
    end
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; frame_tick = 1'b0;
    pulse_cnt = 0; pulse_xl = -1;
    #3;
    chk("rst_valid",   wall_valid,   0);
    chk("rst_passed",  passed,       0);
    chk("rst_xleft",   wall_xleft,   159);
    chk("rst_xright",  wall_xright,  174);
    chk("rst_topy",    wall_topy,    8);
    chk("rst_bottomy", wall_bottomy, 48);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE ignores halt and tick
    halt = 1'b1; frame_tick = 1'b1;
    step(); step();
    halt = 1'b0; frame_tick = 1'b0;
    chk("idle_valid", wall_valid, 0);
    chk("idle_xleft", wall_xleft, 159);

    start = 1'b1; step(); start = 1'b0;
    chk("resp_valid", wall_valid, 0);
    top1 = 7'(8 + int'(m_lfsr[5:0]));
    step();
    chk("spawn_valid",   wall_valid,   1);
    chk("spawn_xleft",   wall_xleft,   159);
    chk("spawn_xright",  wall_xright,  174);
    chk("spawn_topy",    wall_topy,    top1);
    chk("spawn_bottomy", wall_bottomy, top1 + 40);

    // Full traverse 159 -> 0, one passed pulse at 25 -> 24
    pulse_cnt = 0; pulse_xl = -1;
    ticks(159);
    chk("trav_xleft",  wall_xleft, 0);
    chk("trav_xright", wall_xright, 15);
    chk("trav_pulses", pulse_cnt,  1);
    chk("trav_pulse_at", pulse_xl, 24);
    ticks(1);
    chk("wrap_valid",  wall_valid, 0);
    chk("wrap_passed", passed,     0);
    top2 = 7'(8 + int'(m_lfsr[5:0]));
    step();
    chk("wrap_xleft",   wall_xleft, 159);
    chk("wrap_topy",    wall_topy,  top2);
    chk("wrap_newgap",  int'(wall_topy != top1), 1);
    chk("wrap_valid2",  wall_valid, 1);

    // Halt with tick in the same cycle at xleft 100
    ticks(59);
    chk("pre_halt_xleft", wall_xleft, 100);
    halt = 1'b1; frame_tick = 1'b1; step();
    chk("halt_xleft", wall_xleft, 100);
    chk("halt_valid", wall_valid, 1);
    halt = 1'b0;
    repeat (5) step();
    frame_tick = 1'b0;
    chk("halt_hold_xleft", wall_xleft, 100);
    chk("halt_hold_valid", wall_valid, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("halt_start_valid", wall_valid, 0);
    step();
    chk("halt_resp_xleft", wall_xleft, 159);

    // Restart mid-scroll at 70; start beats a concurrent tick
    ticks(89);
    chk("pre_rs_xleft", wall_xleft, 70);
    pulse_cnt = 0;
    start = 1'b1; frame_tick = 1'b1; step();
    start = 1'b0; frame_tick = 1'b0;
    chk("rs_valid", wall_valid, 0);
    top1 = 7'(8 + int'(m_lfsr[5:0]));
    step();
    chk("rs_xleft",  wall_xleft, 159);
    chk("rs_topy",   wall_topy,  top1);
    chk("rs_pulses", pulse_cnt,  0);

    // Async reset between edges, right after a passed pulse
    ticks(135);
    chk("pre_ar_xleft",  wall_xleft, 24);
    chk("pre_ar_passed", passed,     1);
    #2 reset = 1'b1;
    #1;
    chk("ar_passed", passed,     0);
    chk("ar_valid",  wall_valid, 0);
    chk("ar_xleft",  wall_xleft, 159);
    chk("ar_topy",   wall_topy,  8);
    @(posedge clk); #1;
    reset = 1'b0;
    // lfsr A5 -> 4A on the first edge; draw = 8 + 0x0A = 18
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("ar_seed_topy",    wall_topy,    18);
    chk("ar_seed_bottomy", wall_bottomy, 58);
    chk("ar_seed_valid",   wall_valid,   1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
